ff_and_arbiter: RTL and testbench
=================================

Name: ff_and_arbiter

Overview:
Round-robin arbiter and sequencer that shares one AND-gated state flip-flop (op0/op0bar) between NREQ requesters. Each granted requester issues one command: load ip0&ip1, set, clear, or no-op. The block sequences grant, operand capture and commit, then acknowledges the requester. It sits between the per-requester lab logic and the shared flop, and exports the same constant id_num tag as the other Task blocks.

Parameters:
NREQ, 4, number of requesters (2..8); owner width OW = $clog2(NREQ)
ID_NUM, 20'h66165, constant driven on id_num

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous active-high reset
req  input  NREQ  level request, bit i = requester i
cmd  input  2*NREQ  per-requester command, bits [2i+1:2i]: 00 NOP, 01 LOAD_AND, 10 SET, 11 CLR
ip0  input  NREQ  per-requester operand A
ip1  input  NREQ  per-requester operand B
gnt  output  NREQ  one-hot grant, high only in GRANT state
owner  output  OW  index of current/last granted requester
ack  output  1  one-cycle completion pulse to owner
busy  output  1  high when state != IDLE
op0  output  1  shared flop value
op0bar  output  1  always ~op0
id_num  output  20  constant ID_NUM

Behaviour:
- Async reset (clear=1, no clock needed): state=IDLE, gnt=0, ack=0, op0=0 (op0bar=1), owner=0, rr pointer=NREQ-1 (requester 0 has highest priority first). Only id_num is unaffected.
- Reset asserted mid-operation aborts it. No ack is issued and op0 goes to 0. After release, arbitration restarts from requester 0.
- States: IDLE, GRANT, COMMIT. All outputs are registered except op0bar and id_num.
- IDLE: at a clk edge with masked request vector != 0, pick the winner, set gnt to its one-hot bit, latch owner, go to GRANT. Otherwise stay in IDLE.
- Arbitration: search starts at pointer+1 and wraps modulo NREQ. The first set bit wins, and the pointer becomes the winner.
- Masking: during the cycle where ack=1, the owner's req bit is ignored. The requester must drop req in its ack cycle to avoid a re-grant. Other requesters may win at that same edge.
- GRANT (exactly 1 cycle): the owner holds cmd/ip0/ip1 stable. At the edge, the owner's cmd, ip0 and ip1 are captured into internal registers, gnt clears, and the state goes to COMMIT.
- COMMIT (exactly 1 cycle): at the edge, the captured command is applied to op0:
  - LOAD_AND: op0 <= ip0 & ip1
  - SET: op0 <= 1
  - CLR: op0 <= 0
  - NOP: op0 holds
  - Also: ack <= 1, state <= IDLE.
- ack is high for exactly the one IDLE cycle after COMMIT. The new op0 is visible in that same cycle.
- Latency: req high at edge k (in IDLE, not masked) gives gnt during cycle k..k+1, commit at edge k+2, ack in cycle k+2..k+3. Peak throughput is 1 op per 3 cycles.
- Inputs changing outside GRANT have no effect. req dropped during GRANT or COMMIT does not cancel the operation.
- Simultaneous requests: exactly one grant, decided by the rr pointer. gnt is never multi-hot.
- All-requesters-active starvation bound: each requester is served within NREQ operations.
- Unused owner values (NREQ not a power of 2) never occur.

Test Plan:
1. clear=1 mid-COMMIT of a SET op -> immediately gnt=0, ack=0, busy=0, op0=0, op0bar=1, id_num=20'h66165; no ack after release.
2. req=4'b0001, cmd0=01, ip0[0]=1, ip1[0]=1, drop req on ack -> gnt=0001 for 1 cycle, ack 2 cycles later, op0=1; then repeat with ip1[0]=0 -> op0=0.
3. req=4'b1111 held continuously, all cmd=NOP -> grant order 0,1,2,3,0 with owner=0,1,2,3,0; ack every 3rd cycle; op0 unchanged.
4. req=4'b0100 cmd2=10 (SET) then req=4'b0100 cmd2=11 (CLR) -> op0 goes 1 then 0; requester 2 is not re-granted in its ack cycle.
5. Requester 1 changes ip0/ip1 during COMMIT -> op0 reflects the values captured at the GRANT edge only.
6. req=4'b1010 arriving in the ack cycle of owner 1 -> requester 3 wins; requester 1 is masked that cycle and served next.

Source files
------------

// File: rtl/ff_and_arbiter_if.sv
// Requester-side bundle for ff_and_arbiter: per-requester request/command/operands
// plus the shared-flop status returned by the arbiter.
interface ff_and_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned OW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] cmd;
  logic [NREQ-1:0]   ip0;
  logic [NREQ-1:0]   ip1;
  logic [NREQ-1:0]   gnt;
  logic [OW-1:0]     owner;
  logic              ack;
  logic              busy;
  logic              op0;
  logic              op0bar;
  logic [19:0]       id_num;

  modport master (
    output req, cmd, ip0, ip1,
    input  gnt, owner, ack, busy, op0, op0bar, id_num
  );

  modport slave (
    input  req, cmd, ip0, ip1,
    output gnt, owner, ack, busy, op0, op0bar, id_num
  );
endinterface

// File: rtl/ff_and_arbiter.sv
// Round-robin arbiter sequencing grant -> operand capture -> commit onto one
// shared AND-gated flop (op0/op0bar), acknowledging the owner after each commit.
module ff_and_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter logic [19:0] ID_NUM = 20'h66165
) (
  input  logic             clk,
  input  logic             clear,
  ff_and_arbiter_if.slave  bus
);
  localparam int unsigned OW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_e;
  typedef enum logic [1:0] {
    CMD_NOP      = 2'b00,
    CMD_LOAD_AND = 2'b01,
    CMD_SET      = 2'b10,
    CMD_CLR      = 2'b11
  } cmd_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            op0_q, op0_d;
  logic [1:0]      cmd_q, cmd_d;
  logic            a_q, a_d;
  logic            b_q, b_d;

  logic [NREQ-1:0] masked_w;
  logic            found_w;
  logic [OW-1:0]   win_w;
  logic [1:0]      cmd_sel_w;
  logic            a_sel_w;
  logic            b_sel_w;

  // The owner's request is ignored during its ack cycle so a late req drop cannot re-grant it.
  always_comb begin
    masked_w = bus.req;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (ack_q && owner_q == OW'(i)) masked_w[i] = 1'b0;
    end
  end

  always_comb begin
    logic [OW-1:0] cand;
    cand    = '0;
    found_w = 1'b0;
    win_w   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = OW'((32'(ptr_q) + i) % NREQ);
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found_w && cand == OW'(j) && masked_w[j]) begin
          found_w = 1'b1;
          win_w   = cand;
        end
      end
    end
  end

  always_comb begin
    cmd_sel_w = '0;
    a_sel_w   = 1'b0;
    b_sel_w   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) begin
        cmd_sel_w = bus.cmd[2*i +: 2];
        a_sel_w   = bus.ip0[i];
        b_sel_w   = bus.ip1[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = '0;
    ack_d   = 1'b0;
    op0_d   = op0_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (found_w) begin
          owner_d = win_w;
          ptr_d   = win_w;
          for (int unsigned j = 0; j < NREQ; j++) gnt_d[j] = (win_w == OW'(j));
          state_d = GRANT;
        end
      end
      GRANT: begin
        cmd_d   = cmd_sel_w;
        a_d     = a_sel_w;
        b_d     = b_sel_w;
        state_d = COMMIT;
      end
      COMMIT: begin
        unique case (cmd_e'(cmd_q))
          CMD_LOAD_AND: op0_d = a_q & b_q;
          CMD_SET:      op0_d = 1'b1;
          CMD_CLR:      op0_d = 1'b0;
          CMD_NOP:      op0_d = op0_q;
        endcase
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      ptr_q   <= OW'(NREQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      op0_q   <= 1'b0;
      cmd_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      op0_q   <= op0_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.owner  = owner_q;
  assign bus.ack    = ack_q;
  assign bus.busy   = busy_q;
  assign bus.op0    = op0_q;
  assign bus.op0bar = ~op0_q;
  assign bus.id_num = ID_NUM;
endmodule

// File: tb/tb_ff_and_arbiter.sv
// Directed bench for ff_and_arbiter: hand-computed expectations checked with
// immediate assertions after each rising edge.
module tb_ff_and_arbiter;
  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic clear;
  int   n_cmp = 0;
  int   n_err = 0;

  ff_and_arbiter_if #(.NREQ(NREQ)) bus ();

  ff_and_arbiter #(.NREQ(NREQ), .ID_NUM(20'h66165)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear   = 1'b1;
    bus.req = '0;
    bus.cmd = '0;
    bus.ip0 = '0;
    bus.ip1 = '0;
    #2;
    chk("rst_gnt",    bus.gnt,    0);
    chk("rst_ack",    bus.ack,    0);
    chk("rst_busy",   bus.busy,   0);
    chk("rst_op0",    bus.op0,    0);
    chk("rst_op0bar", bus.op0bar, 1);
    chk("rst_owner",  bus.owner,  0);
    chk("rst_id",     bus.id_num, 20'h66165);
    tick; tick;
    clear = 1'b0;

    // LOAD_AND from requester 0 with 1&1, then 1&0
    bus.cmd = 8'b00_00_00_01; bus.ip0 = 4'b0001; bus.ip1 = 4'b0001; bus.req = 4'b0001;
    tick;
    chk("la_gnt",   bus.gnt,   4'b0001);
    chk("la_owner", bus.owner, 0);
    chk("la_busy",  bus.busy,  1);
    chk("la_ack0",  bus.ack,   0);
    tick;
    chk("la_gntclr", bus.gnt,  0);
    chk("la_busy2",  bus.busy, 1);
    tick;
    chk("la_ack",    bus.ack,    1);
    chk("la_op0",    bus.op0,    1);
    chk("la_op0bar", bus.op0bar, 0);
    chk("la_busy3",  bus.busy,   0);
    bus.req = '0;
    tick;
    chk("la_ackend", bus.ack, 0);
    chk("la_nognt",  bus.gnt, 0);
    bus.ip1 = 4'b0000; bus.req = 4'b0001;
    tick;
    chk("la2_gnt", bus.gnt, 4'b0001);
    tick; tick;
    chk("la2_ack", bus.ack, 1);
    chk("la2_op0", bus.op0, 0);
    bus.req = '0;
    tick;
    chk("la2_ackend", bus.ack, 0);

    // SET then CLR from requester 2; req held through ack cycle must not re-grant
    bus.cmd = 8'b00_10_00_00; bus.req = 4'b0100;
    tick;
    chk("set_gnt",   bus.gnt,   4'b0100);
    chk("set_owner", bus.owner, 2);
    tick; tick;
    chk("set_ack", bus.ack, 1);
    chk("set_op0", bus.op0, 1);
    bus.cmd = 8'b00_11_00_00;
    tick;
    chk("mask_gnt",  bus.gnt,  0);
    chk("mask_busy", bus.busy, 0);
    chk("mask_ack",  bus.ack,  0);
    tick;
    chk("clr_gnt",   bus.gnt,   4'b0100);
    chk("clr_owner", bus.owner, 2);
    bus.req = '0;
    tick; tick;
    chk("clr_ack", bus.ack, 1);
    chk("clr_op0", bus.op0, 0);
    tick;
    chk("clr_ackend", bus.ack, 0);

    // Operands changed during COMMIT must not affect the result
    bus.cmd = 8'b00_00_01_00; bus.ip0 = 4'b0010; bus.ip1 = 4'b0010; bus.req = 4'b0010;
    tick;
    chk("cap_gnt",   bus.gnt,   4'b0010);
    chk("cap_owner", bus.owner, 1);
    tick;
    bus.ip0 = '0; bus.ip1 = '0; bus.req = '0; bus.cmd = 8'b00_00_11_00;
    tick;
    chk("cap_ack", bus.ack, 1);
    chk("cap_op0", bus.op0, 1);
    tick;

    // Requester 3 wins in owner 1's ack cycle; requester 1 is served next
    bus.cmd = '0; bus.req = 4'b0010;
    tick;
    chk("rr_gnt1", bus.gnt, 4'b0010);
    tick; tick;
    chk("rr_ack1",   bus.ack,   1);
    chk("rr_owner1", bus.owner, 1);
    bus.req = 4'b1010;
    tick;
    chk("rr_gnt3",   bus.gnt,   4'b1000);
    chk("rr_owner3", bus.owner, 3);
    tick; tick;
    chk("rr_ack3", bus.ack, 1);
    tick;
    chk("rr_gnt1b",   bus.gnt,   4'b0010);
    chk("rr_owner1b", bus.owner, 1);
    bus.req = '0;
    tick; tick;
    chk("rr_ack1b", bus.ack, 1);
    chk("rr_op0",   bus.op0, 1);
    tick;

    // Reset in the middle of a SET commit
    bus.cmd = 8'b00_00_00_10; bus.req = 4'b0001;
    tick;
    chk("ab_gnt", bus.gnt, 4'b0001);
    tick;
    #3 clear = 1'b1;
    #1;
    chk("ab_gnt0",   bus.gnt,    0);
    chk("ab_ack",    bus.ack,    0);
    chk("ab_busy",   bus.busy,   0);
    chk("ab_op0",    bus.op0,    0);
    chk("ab_op0bar", bus.op0bar, 1);
    chk("ab_owner",  bus.owner,  0);
    chk("ab_id",     bus.id_num, 20'h66165);
    bus.req = '0;
    tick;
    clear = 1'b0;
    tick;
    chk("ab_noack1", bus.ack,  0);
    chk("ab_op0b",   bus.op0,  0);
    chk("ab_busyb",  bus.busy, 0);
    tick;
    chk("ab_noack2", bus.ack, 0);

    // All requesting with NOP: order restarts from requester 0 after reset
    bus.cmd = '0; bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("all_gnt",   bus.gnt,   32'(1) << (k % 4));
      chk("all_owner", bus.owner, k % 4);
      tick;
      chk("all_mid_ack", bus.ack, 0);
      tick;
      chk("all_ack", bus.ack, 1);
      chk("all_op0", bus.op0, 0);
    end
    bus.req = '0;
    tick;
    chk("all_end_gnt", bus.gnt,  0);
    chk("all_end_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
